// File: rtl/ifu_pkg.sv
// Shared constants and state encoding for the instruction fetch unit.
// Widths match the instruction memory and the 262-bit matrix-CPU bus.
package ifu_pkg;
    localparam int IFU_BUS_W   = 262;
    localparam int IFU_INSTR_W = 256;
    localparam int IFU_ADDR_W  = 7;

    localparam logic [7:0] HALT_OPCODE = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LATCH,
        S_READ,
        S_VALID,
        S_HALT
    } ifu_state_e;
endpackage

// File: rtl/ifu_pc_counter.sv
// Program counter: load on redirect, increment on accepted fetch, wraps at 2^ADDR_W.
// Latency: new value visible the cycle after load/inc. No backpressure.
// Load has priority over increment.
import ifu_pkg::*;

module ifu_pc_counter #(
    parameter int                ADDR_W   = IFU_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] pc
);
    logic [ADDR_W-1:0] pc_d, pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_val;
        end else if (inc) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch sequencer: drives address/strobes on the shared bus, captures the word, hands it to decode.
// Latency: 3 cycles S_ADDR->instr_valid, one fetch per 4 cycles; holds in S_VALID until instr_ready.
// IFU_HALT_DETECT_EN: stop fetching after a delivered 8'hFF opcode until branch or reset.
import ifu_pkg::*;

module instruction_fetch_unit #(
    parameter int BUS_W    = IFU_BUS_W,
    parameter int INSTR_W  = IFU_INSTR_W,
    parameter int ADDR_W   = IFU_ADDR_W,
    parameter int RESET_PC = 0
) (
    input  logic               clock,
    input  logic               reset,
    inout  wire  [BUS_W-1:0]   bus,
    output logic               im_enable,
    output logic               im_import_address,
    output logic               im_read,
    input  logic               run,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               branch_valid,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               halted
);
    ifu_state_e         state_d, state_q;
    logic               bus_oe_d, bus_oe_q;
    logic               en_d, en_q;
    logic               imp_d, imp_q;
    logic               rd_d, rd_q;
    logic               vld_d, vld_q;
    logic [INSTR_W-1:0] data_d, data_q;
    logic [ADDR_W-1:0]  ipc_d, ipc_q;
    logic               halted_d, halted_q;
    logic               pc_load, pc_inc, halt_hit;
    logic [ADDR_W-1:0]  pc;

    ifu_pc_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (ADDR_W'(RESET_PC))
    ) u_pc (
        .clock    (clock),
        .reset    (reset),
        .load     (pc_load),
        .inc      (pc_inc),
        .load_val (branch_target),
        .pc       (pc)
    );

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        ipc_d    = ipc_q;
        halted_d = halted_q;
        pc_load  = 1'b0;
        pc_inc   = 1'b0;
        halt_hit = 1'b0;
`ifdef IFU_HALT_DETECT_EN
        halt_hit = (data_q[INSTR_W-1 -: 8] == HALT_OPCODE);
`endif
        // Redirect beats handshake and run; an in-flight fetch is simply abandoned.
        if (branch_valid) begin
            pc_load = 1'b1;
            if (state_q != S_IDLE) begin
                state_d  = S_ADDR;
                halted_d = 1'b0;
            end
        end else begin
            case (state_q)
                S_IDLE:  if (run) state_d = S_ADDR;
                S_ADDR:  state_d = S_LATCH;
                S_LATCH: state_d = S_READ;
                S_READ: begin
                    data_d  = bus[INSTR_W-1:0];
                    ipc_d   = pc;
                    state_d = S_VALID;
                end
                S_VALID: begin
                    if (instr_ready) begin
                        if (halt_hit) begin
                            halted_d = 1'b1;
                            state_d  = S_HALT;
                        end else begin
                            pc_inc  = 1'b1;
                            state_d = run ? S_ADDR : S_IDLE;
                        end
                    end
                end
                S_HALT:  state_d = S_HALT;
                default: state_d = S_IDLE;
            endcase
        end

        // Outputs are decoded from the next state so they register cleanly with it.
        bus_oe_d = (state_d == S_ADDR) || (state_d == S_LATCH);
        en_d     = bus_oe_d || (state_d == S_READ);
        imp_d    = (state_d == S_LATCH);
        rd_d     = (state_d == S_READ);
        vld_d    = (state_d == S_VALID);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            bus_oe_q <= 1'b0;
            en_q     <= 1'b0;
            imp_q    <= 1'b0;
            rd_q     <= 1'b0;
            vld_q    <= 1'b0;
            data_q   <= '0;
            ipc_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            bus_oe_q <= bus_oe_d;
            en_q     <= en_d;
            imp_q    <= imp_d;
            rd_q     <= rd_d;
            vld_q    <= vld_d;
            data_q   <= data_d;
            ipc_q    <= ipc_d;
            halted_q <= halted_d;
        end
    end

    assign bus               = bus_oe_q ? {{(BUS_W-ADDR_W){1'b0}}, pc} : 'z;
    assign im_enable         = en_q;
    assign im_import_address = imp_q;
    assign im_read           = rd_q;
    assign instr_valid       = vld_q;
    assign instr_data        = data_q;
    assign instr_pc          = ipc_q;
    assign halted            = halted_q;

    bus_turnaround_a: assert property (@(posedge clock) disable iff (reset) !(bus_oe_q && rd_q));
endmodule
